mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/rv_mem_pkg.sv | 20 ++
 rtl/mem_port_arbiter_lat_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// Purpose: shared types and widths for the instruction/data memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rv_mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Purpose: loadable down-counter that times the memory read latency.
// Latency: count updates one cycle after load/dec; zero is combinational.
// Backpressure: none; stops at zero and waits for the next load.
// Ports: clk, reset (sync, active-high), load/load_val, dec, count, zero.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one fixed-latency memory port between fetch and load/store requesters.
// Latency: grant same cycle as request (when idle); mem_en next cycle; rvalid MEM_LAT cycles after mem_en.
// Backpressure: a request waits (no grant) while a transaction is in flight; data wins unless fetch is starved.
// Ports: clk/reset; fetch side i_req/i_addr -> i_gnt/i_rvalid/i_rdata;
//        data side d_req/d_we/d_be/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata;
//        memory side mem_en/mem_we/mem_be/mem_addr/mem_wdata <- mem_rdata.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int MEM_LAT    = 2,  // legal 1..15
  parameter int STARVE_MAX = 4   // legal 1..15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [BE_W-1:0] d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state, state_nxt;
  arb_owner_t owner;
  logic [3:0] streak;
  logic [3:0] lat_count;
  logic       lat_zero;
  logic       resp;
  logic       grant_ok;
  logic       pick_i;
  logic       cnt_load;
  logic       cnt_dec;

  lat_counter #(.W(4)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .count    (lat_count),
    .zero     (lat_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    resp      = 1'b0;
    grant_ok  = 1'b0;
    pick_i    = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    // The final WAIT cycle doubles as an arbitration slot so that
    // back-to-back transactions cost MEM_LAT+1 cycles each.
    resp     = (state == ARB_WAIT) && lat_zero;
    grant_ok = !reset && ((state == ARB_IDLE) || resp);
    pick_i   = i_req && (!d_req || (streak == STARVE_LIM));
    i_gnt    = grant_ok && pick_i;
    d_gnt    = grant_ok && d_req && !pick_i;

    case (state)
      ARB_IDLE: begin
        if (i_gnt || d_gnt) state_nxt = ARB_CMD;
      end
      ARB_CMD: begin
        cnt_load  = 1'b1;
        state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_dec = 1'b1;
        if (resp) state_nxt = (i_gnt || d_gnt) ? ARB_CMD : ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_I;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= i_gnt || d_gnt;
      if (i_gnt) begin
        owner    <= OWN_I;
        mem_we   <= 1'b0;
        mem_be   <= '1;
        mem_addr <= i_addr;
      end else if (d_gnt) begin
        owner     <= OWN_D;
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end

      // Streak only counts data grants that actually made fetch wait.
      if (i_gnt) begin
        streak <= '0;
      end else if (d_gnt && i_req && (streak != STARVE_LIM)) begin
        streak <= streak + 1'b1;
      end
    end
  end

  // Reset in the response cycle abandons the transaction, so gate rvalid.
  assign i_rvalid = resp && !reset && (owner == OWN_I);
  assign d_rvalid = resp && !reset && (owner == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule
